// File: rtl/ibex_csr_rmw_ctrl.sv
// Read-modify-write sequencer for a single CSR storage element: samples the
// old value, issues at most one masked write pulse, then returns old value + error.
module ibex_csr_rmw_ctrl #(
  parameter int unsigned      Width       = 32,
  parameter logic [Width-1:0] WriteMask   = {Width{1'b1}},
  parameter int unsigned      ErrCntWidth = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [1:0]             req_op_i,
  input  logic [Width-1:0]       req_wdata_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [Width-1:0]       rsp_rdata_o,
  output logic                   rsp_error_o,
  output logic                   csr_wr_en_o,
  output logic [Width-1:0]       csr_wr_data_o,
  input  logic [Width-1:0]       csr_rd_data_i,
  input  logic                   csr_rd_error_i,
  output logic [ErrCntWidth-1:0] err_cnt_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    CAPTURE = 2'b01,
    COMMIT  = 2'b10,
    RESP    = 2'b11
  } state_e;

  localparam logic [1:0] OpRead  = 2'b00;
  localparam logic [1:0] OpWrite = 2'b01;
  localparam logic [1:0] OpSet   = 2'b10;
  localparam logic [1:0] OpClear = 2'b11;

  state_e                 state_q, state_d;
  logic [1:0]             op_q, op_d;
  logic [Width-1:0]       wdata_q, wdata_d;
  logic [Width-1:0]       old_q, old_d;
  logic                   err_q, err_d;
  logic [ErrCntWidth-1:0] err_cnt_q, err_cnt_d;
  logic                   wr_en_q, wr_en_d;
  logic [Width-1:0]       wr_data_q, wr_data_d;

  // Masked new value; non-writable bits always keep the old value.
  function automatic logic [Width-1:0] merge_value(input logic [1:0]       op,
                                                   input logic [Width-1:0] old_val,
                                                   input logic [Width-1:0] operand);
    logic [Width-1:0] computed;
    case (op)
      OpWrite: computed = operand;
      OpSet:   computed = old_val | operand;
      OpClear: computed = old_val & ~operand;
      default: computed = old_val;
    endcase
    return (old_val & ~WriteMask) | (computed & WriteMask);
  endfunction

  // Next-state and datapath decode.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    wdata_d   = wdata_q;
    old_d     = old_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    wr_en_d   = 1'b0;
    wr_data_d = {Width{1'b0}};
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          op_d    = req_op_i;
          wdata_d = req_wdata_i;
          state_d = CAPTURE;
        end else begin
          state_d = IDLE;
        end
      end
      CAPTURE: begin
        old_d = csr_rd_data_i;
        err_d = csr_rd_error_i;
        if (csr_rd_error_i && (err_cnt_q != {ErrCntWidth{1'b1}})) begin
          err_cnt_d = err_cnt_q + ErrCntWidth'(1);
        end else begin
          err_cnt_d = err_cnt_q;
        end
        // The write strobe and data are registered here so COMMIT drives them from flops.
        if (op_q != OpRead) begin
          state_d   = COMMIT;
          wr_data_d = merge_value(op_q, csr_rd_data_i, wdata_q);
          wr_en_d   = !csr_rd_error_i &&
                      !(((op_q == OpSet) || (op_q == OpClear)) && (wdata_q == {Width{1'b0}}));
        end else begin
          state_d = RESP;
        end
      end
      COMMIT: begin
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      op_q      <= 2'b00;
      wdata_q   <= {Width{1'b0}};
      old_q     <= {Width{1'b0}};
      err_q     <= 1'b0;
      err_cnt_q <= {ErrCntWidth{1'b0}};
      wr_en_q   <= 1'b0;
      wr_data_q <= {Width{1'b0}};
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wdata_q   <= wdata_d;
      old_q     <= old_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign req_ready_o   = (state_q == IDLE);
  assign rsp_valid_o   = (state_q == RESP);
  assign rsp_rdata_o   = (state_q == RESP) ? old_q : {Width{1'b0}};
  assign rsp_error_o   = (state_q == RESP) & err_q;
  assign csr_wr_en_o   = wr_en_q;
  assign csr_wr_data_o = wr_data_q;
  assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_ibex_csr_rmw_ctrl.sv
// Scoreboard bench for ibex_csr_rmw_ctrl with a partial write mask and a 2-bit error counter.
module tb_ibex_csr_rmw_ctrl;

  localparam int unsigned W      = 32;
  localparam logic [31:0] TbMask = 32'h0000_FFFF;
  localparam logic [1:0]  OP_RD  = 2'b00;
  localparam logic [1:0]  OP_WR  = 2'b01;
  localparam logic [1:0]  OP_SET = 2'b10;
  localparam logic [1:0]  OP_CLR = 2'b11;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [W-1:0]  req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_rdata;
  logic          rsp_error;
  logic          wr_en;
  logic [W-1:0]  wr_data;
  logic [W-1:0]  rd_data;
  logic          rd_error;
  logic [1:0]    err_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;

  logic [31:0] exp_wr_q[$];
  logic [31:0] exp_rdata_q[$];
  logic        exp_err_q[$];

  ibex_csr_rmw_ctrl #(
    .Width(32), .WriteMask(TbMask), .ErrCntWidth(2)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_error_o(rsp_error),
    .csr_wr_en_o(wr_en), .csr_wr_data_o(wr_data),
    .csr_rd_data_i(rd_data), .csr_rd_error_i(rd_error),
    .err_cnt_o(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write pulse and every response handshake is matched against the queues.
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      if (exp_wr_q.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
      else check("wr_data", wr_data, exp_wr_q.pop_front());
    end
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_rdata_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
      else begin
        check("rsp_rdata", rsp_rdata, exp_rdata_q.pop_front());
        check("rsp_error", {31'd0, rsp_error}, {31'd0, exp_err_q.pop_front()});
      end
    end
  end

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] oldv,
                                        input logic [31:0] wd);
    logic [31:0] c;
    if (op == OP_WR) c = wd;
    else if (op == OP_SET) c = oldv | wd;
    else if (op == OP_CLR) c = oldv & ~wd;
    else c = oldv;
    return (oldv & ~TbMask) | (c & TbMask);
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] wd, input logic [31:0] csr_val,
                        input logic err, input int hold);
    logic exp_en;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_wdata = wd; rd_data = csr_val;
    exp_en = !err && (op != OP_RD) && !((op == OP_SET || op == OP_CLR) && wd == 32'd0);
    if (exp_en) exp_wr_q.push_back(model(op, csr_val, wd));
    exp_rdata_q.push_back(csr_val);
    exp_err_q.push_back(err);
    if (err && exp_cnt < 3) exp_cnt++;
    @(negedge clk); check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; rd_error = err;
    @(negedge clk);
    check("cap_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("cap_wr_en", {31'd0, wr_en}, 32'd0);
    @(posedge clk); #1;
    rd_error = 1'b0;
    @(negedge clk);
    check("err_cnt", {30'd0, err_cnt}, exp_cnt);
    if (op == OP_RD) begin
      check("rd_wr_en", {31'd0, wr_en}, 32'd0);
    end else begin
      check("commit_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("commit_wr_en", {31'd0, wr_en}, {31'd0, exp_en});
      @(posedge clk); #1;
      @(negedge clk);
    end
    check("rsp_valid_lat", {31'd0, rsp_valid}, 32'd1);
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_rdata", rsp_rdata, csr_val);
      check("hold_error", {31'd0, rsp_error}, {31'd0, err});
      check("hold_req_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
      req_valid = (i == 0);
      req_op = OP_WR; req_wdata = 32'hDEAD_BEEF;
      @(negedge clk);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("post_req_ready", {31'd0, req_ready}, 32'd1);
    check("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_wdata = 32'd0;
    rsp_ready = 1'b0; rd_data = 32'd0; rd_error = 1'b0;
    #12;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst_err_cnt", {30'd0, err_cnt}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    run_op(OP_RD,  32'h0000_0000, 32'h1234_5678, 1'b0, 0);
    run_op(OP_SET, 32'h0000_000F, 32'h0000_00F0, 1'b0, 0);
    run_op(OP_CLR, 32'hFFFF_0000, 32'hFFFF_FFFF, 1'b0, 0);
    run_op(OP_CLR, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    run_op(OP_WR,  32'h1234_5678, 32'hAAAA_AAAA, 1'b0, 0);
    run_op(OP_WR,  32'h0000_0005, 32'h0000_0005, 1'b0, 0);
    run_op(OP_SET, 32'h0000_0100, 32'h0000_0011, 1'b0, 4);
    run_op(OP_WR,  32'h0000_1234, 32'h0000_0000, 1'b1, 0);
    run_op(OP_RD,  32'h0000_0000, 32'h0000_0055, 1'b1, 0);
    run_op(OP_SET, 32'h0000_00FF, 32'h0000_0000, 1'b1, 1);
    run_op(OP_CLR, 32'h0000_00FF, 32'h0000_FFFF, 1'b1, 0);
    run_op(OP_WR,  32'h0000_4321, 32'h0000_0000, 1'b1, 0);

    // Reset while the write pulse is on the bus: response must be dropped.
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = OP_WR; req_wdata = 32'h0000_1111; rd_data = 32'd0;
    exp_wr_q.push_back(32'h0000_1111);
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); #2;
    rst_n = 1'b0; exp_cnt = 0;
    #1;
    check("mid_rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("mid_rst_err_cnt", {30'd0, err_cnt}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    check("rel_req_ready", {31'd0, req_ready}, 32'd1);
    check("rel_rsp_valid", {31'd0, rsp_valid}, 32'd0);

    run_op(OP_RD, 32'h0000_0000, 32'hCAFE_0001, 1'b0, 0);

    @(posedge clk); #1;
    check("wr_q_empty", exp_wr_q.size(), 32'd0);
    check("rsp_q_empty", exp_rdata_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ibex_csr_rmw_ctrl.md
Name: ibex_csr_rmw_ctrl

Overview:
- Read-modify-write sequencer sitting directly upstream of a single CSR storage element. It is the sole driver of that element's write enable and write data, and the sole consumer of its read data and read-error outputs.
- Accepts CSR access requests (read / write / set / clear) over a valid/ready handshake.
- Samples the current CSR value and computes the masked new value. It issues at most one single-cycle write pulse, then returns the old value plus an integrity-error flag over a response handshake.
- Shadow-copy mismatches reported by the storage element suppress the write and are counted.

Parameters:
- Width, 32, CSR data width in bits.
- WriteMask, all ones (Width bits), bits set are software-writable; clear bits keep their old value on every write.
- ErrCntWidth, 8, width of the saturating integrity-error counter.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- req_valid_i  input  1  request valid.
- req_ready_o  output  1  request ready; high only in IDLE.
- req_op_i  input  2  operation: 00 read, 01 write, 10 set, 11 clear.
- req_wdata_i  input  Width  operand.
- rsp_valid_o  output  1  response valid.
- rsp_ready_i  input  1  response ready.
- rsp_rdata_o  output  Width  CSR value sampled before modification.
- rsp_error_o  output  1  integrity error detected for this access.
- csr_wr_en_o  output  1  write strobe to the CSR element.
- csr_wr_data_o  output  Width  write data to the CSR element.
- csr_rd_data_i  input  Width  current CSR value.
- csr_rd_error_i  input  1  CSR shadow mismatch.
- err_cnt_o  output  ErrCntWidth  saturating count of integrity errors.

Behaviour:
- FSM states: IDLE, CAPTURE, COMMIT, RESP. Reset state is IDLE.
- Reset values: all outputs 0, req_ready_o = 1, err_cnt_o = 0. Op, operand and old-value registers reset to 0.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i & req_ready_o (cycle N): register op and operand, go to CAPTURE.
- CAPTURE (cycle N+1):
  - Register csr_rd_data_i as old_q and csr_rd_error_i as err_q.
  - If csr_rd_error_i = 1, increment err_cnt_o; saturate at all ones, never wrap.
  - Next state is COMMIT if op is not read; otherwise RESP.
- COMMIT (cycle N+2):
  - Compute new value: write -> wdata; set -> old_q | wdata; clear -> old_q & ~wdata.
  - Apply mask: csr_wr_data_o = (old_q & ~WriteMask) | (computed & WriteMask).
  - Assert csr_wr_en_o for exactly this cycle, unless err_q = 1, or op is set/clear with wdata = 0. In either case csr_wr_en_o stays 0.
  - Always go to RESP.
- RESP (cycle N+3 for modifying ops, N+2 for read):
  - rsp_valid_o = 1, rsp_rdata_o = old_q, rsp_error_o = err_q.
  - All three are held stable until rsp_ready_i. On rsp_valid_o & rsp_ready_i, return to IDLE.
- Throughput: a new request is accepted no earlier than the cycle after the response handshake; there are no back-to-back overlaps.
- csr_wr_data_o outside COMMIT: don't-care functionally, driven to 0.
- Write data that equals old_q is still written; no compare-skip.
- req_valid_i outside IDLE is ignored. req_op_i and req_wdata_i are sampled only on the accept edge.
- Asynchronous reset mid-operation: immediate return to IDLE with all outputs at reset values. No write pulse is issued and the pending response is dropped.
- err_cnt_o is cleared only by reset.

Test Plan:
- Read with CSR = 0x1234_5678 -> rsp_valid_o at N+2, rsp_rdata_o = 0x1234_5678, rsp_error_o = 0, csr_wr_en_o never high.
- Set with old 0x0000_00F0, wdata 0x0000_000F -> single wr_en pulse at N+2 with data 0x0000_00FF; response rdata 0x0000_00F0 at N+3.
- Clear with old 0xFFFF_FFFF, wdata 0xFFFF_0000, WriteMask = 0x0000_FFFF -> write data 0xFFFF_FFFF (masked bits retained). Clear with wdata 0 -> no wr_en.
- csr_rd_error_i = 1 during CAPTURE of a write -> no wr_en, rsp_error_o = 1, err_cnt_o increments 0 -> 1. With ErrCntWidth = 2, 5 such errors -> err_cnt_o = 3.
- Hold rsp_ready_i = 0 for 4 cycles in RESP -> rsp outputs stable, req_ready_o = 0, second request ignored until handshake.
- Assert rst_ni low during COMMIT -> csr_wr_en_o = 0 immediately, FSM IDLE, rsp_valid_o = 0, req_ready_o = 1 after release.
